// File: rtl/llr_psk_demapper_ser.sv
`default_nettype none
// ============================================================================
// Module   : llr_psk_demapper_ser
// Brief    : BPSK/QPSK/8PSK max-log LLR demapper with a 2-stage compute
//            pipeline, a symbol FIFO and a serial (one LLR per transfer)
//            valid/ready output.
// Optional : define LLR_PSK_DEMAPPER_SAT_CNT_EN to enable the saturation
//            event counter on osat_cnt (otherwise osat_cnt is tied to 0).
// Revision : 1.0 - initial release
// ============================================================================
module llr_psk_demapper_ser #(
   parameter int pDAT_W      = 8,
   parameter int pLLR_W      = 4,
   parameter int pFIFO_DEPTH = 4
) (
   input  logic                     iclk,
   input  logic                     ireset,
   input  logic                     iclkena,
   input  logic                     ival,
   input  logic                     isop,
   input  logic [1:0]               iqam,
   input  logic signed [pDAT_W-1:0] idat_re,
   input  logic signed [pDAT_W-1:0] idat_im,
   output logic                     ordy,
   input  logic                     irdy,
   output logic                     oval,
   output logic                     osop,
   output logic                     olast,
   output logic signed [pLLR_W-1:0] oLLR,
   output logic [15:0]              osat_cnt
);

   // Full-precision arithmetic width, FIFO pointer/count widths, entry width
   localparam int W1 = pDAT_W + 1;
   localparam int PW = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;
   localparam int CW = $clog2(pFIFO_DEPTH + 1);
   localparam int EW = 3*pLLR_W + 3;
   localparam logic signed [W1-1:0] LLR_MAX = W1'(2**(pLLR_W-1) - 1);
   localparam logic signed [W1-1:0] LLR_MIN = W1'(-(2**(pLLR_W-1)));

   // FIFO entry layout: {sop, qam[1:0], llr2, llr1, llr0}
   function automatic logic [pLLR_W-1:0] clip(input logic signed [W1-1:0] v);
      logic signed [W1-1:0] c;
      if (v > LLR_MAX)      c = LLR_MAX;
      else if (v < LLR_MIN) c = LLR_MIN;
      else                  c = v;
      return c[pLLR_W-1:0];
   endfunction

`ifdef LLR_PSK_DEMAPPER_SAT_CNT_EN
   function automatic logic [1:0] is_sat(input logic signed [W1-1:0] v);
      return ((v > LLR_MAX) || (v < LLR_MIN)) ? 2'd1 : 2'd0;
   endfunction
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(pFIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [pLLR_W-1:0] sel_llr(input logic [EW-1:0] e, input logic [1:0] idx);
      case (idx)
         2'd0:    return e[pLLR_W-1:0];
         2'd1:    return e[2*pLLR_W-1:pLLR_W];
         default: return e[3*pLLR_W-1:2*pLLR_W];
      endcase
   endfunction

   // Stage 1: registered inputs plus magnitudes
   logic                 s1_val_q, s1_val_d;
   logic                 s1_sop_q, s1_sop_d;
   logic [1:0]           s1_qam_q, s1_qam_d;
   logic signed [W1-1:0] s1_re_q, s1_re_d;
   logic signed [W1-1:0] s1_im_q, s1_im_d;
   logic signed [W1-1:0] s1_abs_re_q, s1_abs_re_d;
   logic signed [W1-1:0] s1_abs_im_q, s1_abs_im_d;

   // Stage 2: saturated LLRs ready to be written into the FIFO
   logic                 s2_val_q, s2_val_d;
   logic                 s2_sop_q, s2_sop_d;
   logic [1:0]           s2_qam_q, s2_qam_d;
   logic [pLLR_W-1:0]    s2_llr0_q, s2_llr0_d;
   logic [pLLR_W-1:0]    s2_llr1_q, s2_llr1_d;
   logic [pLLR_W-1:0]    s2_llr2_q, s2_llr2_d;
   logic signed [W1-1:0] b0, b1, b2;

   // Symbol FIFO
   logic [EW-1:0]        fifo_mem_q [pFIFO_DEPTH];
   logic [EW-1:0]        fifo_wdata;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
   logic [CW-1:0]        cnt_after_pop;
   logic [CW:0]          occupancy;

   // Serial output stage (a registered view of the FIFO head)
   logic                 oval_q, oval_d;
   logic                 osop_q, osop_d;
   logic                 olast_q, olast_d;
   logic [pLLR_W-1:0]    ollr_q, ollr_d;
   logic [1:0]           bit_idx_q, bit_idx_d;
   logic [1:0]           idx_next;
   logic [EW-1:0]        head;
   logic                 transfer, pop;

`ifdef LLR_PSK_DEMAPPER_SAT_CNT_EN
   logic [1:0]           s2_nsat_q, s2_nsat_d;
   logic [15:0]          sat_cnt_q, sat_cnt_d;
   logic [16:0]          sat_sum;
`endif

   // Upstream ready counts every symbol already committed to a FIFO slot
   always_comb begin
      occupancy = {1'b0, fifo_cnt_q} + (CW+1)'(s1_val_q) + (CW+1)'(s2_val_q);
      ordy      = (occupancy < (CW+1)'(pFIFO_DEPTH));
   end

   // Next-state logic for pipeline, FIFO pointers and serialiser
   always_comb begin
      // stage 1: iqam = 0 symbols are accepted but never become valid
      s1_val_d    = ival & ordy & (iqam != 2'd0);
      s1_sop_d    = isop;
      s1_qam_d    = iqam;
      s1_re_d     = {idat_re[pDAT_W-1], idat_re};
      s1_im_d     = {idat_im[pDAT_W-1], idat_im};
      s1_abs_re_d = s1_re_d[W1-1] ? -s1_re_d : s1_re_d;
      s1_abs_im_d = s1_im_d[W1-1] ? -s1_im_d : s1_im_d;

      // stage 2: unused bit positions stay zero so they never saturate
      b0 = '0;
      b1 = '0;
      b2 = '0;
      case (s1_qam_q)
         2'd1: begin
            b0 = s1_re_q;
         end
         2'd2: begin
            b0 = s1_re_q;
            b1 = s1_im_q;
         end
         2'd3: begin
            b0 = s1_abs_re_q - s1_abs_im_q;
            b1 = s1_re_q;
            b2 = s1_im_q;
         end
         default: ;
      endcase
      s2_val_d  = s1_val_q;
      s2_sop_d  = s1_sop_q;
      s2_qam_d  = s1_qam_q;
      s2_llr0_d = clip(b0);
      s2_llr1_d = clip(b1);
      s2_llr2_d = clip(b2);
`ifdef LLR_PSK_DEMAPPER_SAT_CNT_EN
      s2_nsat_d = is_sat(b0) + is_sat(b1) + is_sat(b2);
      sat_sum   = {1'b0, sat_cnt_q} + 17'(s2_nsat_q);
      sat_cnt_d = sat_cnt_q;
      if (s2_val_q) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
`endif

      // FIFO: write from stage 2, pop on transfer of an entry's last LLR
      fifo_wdata    = {s2_sop_q, s2_qam_q, s2_llr2_q, s2_llr1_q, s2_llr0_q};
      transfer      = oval_q & irdy;
      pop           = transfer & olast_q;
      wr_ptr_d      = s2_val_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_after_pop = fifo_cnt_q - CW'(pop);
      fifo_cnt_d    = cnt_after_pop + CW'(s2_val_q);

      // serialiser: hold while stalled, else present the next LLR of the
      // head entry; only entries already stored are visible (no bypass)
      idx_next  = pop ? 2'd0 : (transfer ? bit_idx_q + 2'd1 : bit_idx_q);
      head      = fifo_mem_q[rd_ptr_d];
      oval_d    = oval_q;
      osop_d    = osop_q;
      olast_d   = olast_q;
      ollr_d    = ollr_q;
      bit_idx_d = bit_idx_q;
      if (!(oval_q && !irdy)) begin
         bit_idx_d = idx_next;
         if (cnt_after_pop != '0) begin
            oval_d  = 1'b1;
            ollr_d  = sel_llr(head, idx_next);
            osop_d  = head[EW-1] & (idx_next == 2'd0);
            olast_d = (idx_next == (head[EW-2:EW-3] - 2'd1));
         end else begin
            oval_d  = 1'b0;
            ollr_d  = '0;
            osop_d  = 1'b0;
            olast_d = 1'b0;
         end
      end
   end

   // State registers: reset wins over the clock enable
   always_ff @(posedge iclk) begin
      if (ireset) begin
         s1_val_q    <= 1'b0;
         s1_sop_q    <= 1'b0;
         s1_qam_q    <= '0;
         s1_re_q     <= '0;
         s1_im_q     <= '0;
         s1_abs_re_q <= '0;
         s1_abs_im_q <= '0;
         s2_val_q    <= 1'b0;
         s2_sop_q    <= 1'b0;
         s2_qam_q    <= '0;
         s2_llr0_q   <= '0;
         s2_llr1_q   <= '0;
         s2_llr2_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         oval_q      <= 1'b0;
         osop_q      <= 1'b0;
         olast_q     <= 1'b0;
         ollr_q      <= '0;
         bit_idx_q   <= '0;
`ifdef LLR_PSK_DEMAPPER_SAT_CNT_EN
         s2_nsat_q   <= '0;
         sat_cnt_q   <= '0;
`endif
      end else if (iclkena) begin
         s1_val_q    <= s1_val_d;
         s1_sop_q    <= s1_sop_d;
         s1_qam_q    <= s1_qam_d;
         s1_re_q     <= s1_re_d;
         s1_im_q     <= s1_im_d;
         s1_abs_re_q <= s1_abs_re_d;
         s1_abs_im_q <= s1_abs_im_d;
         s2_val_q    <= s2_val_d;
         s2_sop_q    <= s2_sop_d;
         s2_qam_q    <= s2_qam_d;
         s2_llr0_q   <= s2_llr0_d;
         s2_llr1_q   <= s2_llr1_d;
         s2_llr2_q   <= s2_llr2_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         oval_q      <= oval_d;
         osop_q      <= osop_d;
         olast_q     <= olast_d;
         ollr_q      <= ollr_d;
         bit_idx_q   <= bit_idx_d;
`ifdef LLR_PSK_DEMAPPER_SAT_CNT_EN
         s2_nsat_q   <= s2_nsat_d;
         sat_cnt_q   <= sat_cnt_d;
`endif
      end
   end

   // FIFO storage: data only, validity is tracked by the pointers
   always_ff @(posedge iclk) begin
      if (!ireset && iclkena && s2_val_q) begin
         fifo_mem_q[wr_ptr_q] <= fifo_wdata;
      end
   end

   assign oval  = oval_q;
   assign osop  = osop_q;
   assign olast = olast_q;
   assign oLLR  = ollr_q;
`ifdef LLR_PSK_DEMAPPER_SAT_CNT_EN
   assign osat_cnt = sat_cnt_q;
`else
   assign osat_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_llr_psk_demapper_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_llr_psk_demapper_ser
// Brief    : Scoreboard bench for llr_psk_demapper_ser; expected LLRs are
//            queued when stimulus is issued and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_llr_psk_demapper_ser;

   logic              clk = 1'b0;
   logic              ireset, iclkena, ival, isop, irdy;
   logic [1:0]        iqam;
   logic signed [7:0] idat_re, idat_im;
   logic              ordy, oval, osop, olast;
   logic signed [3:0] oLLR;
   logic [15:0]       osat_cnt;

   llr_psk_demapper_ser #(.pDAT_W(8), .pLLR_W(4), .pFIFO_DEPTH(4)) dut (
      .iclk(clk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop),
      .iqam(iqam), .idat_re(idat_re), .idat_im(idat_im), .ordy(ordy), .irdy(irdy),
      .oval(oval), .osop(osop), .olast(olast), .oLLR(oLLR), .osat_cnt(osat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic signed [3:0] llr;
      logic              sop;
      logic              last;
   } exp_t;

   typedef struct {
      int q; int re; int im; int sop; int l0; int l1; int l2; int nsat;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pops   = 0;
   int   exp_sat  = 0;

   // hand-computed vectors (pLLR_W = 4: range -8..7)
   vec_t dir_v [0:8] = '{
      '{3,   20,   -6, 0,  7,  7, -6, 2},
      '{1, -100,    0, 1, -8,  0,  0, 1},
      '{1,    7,    0, 0,  7,  0,  0, 0},
      '{1,    8,    0, 0,  7,  0,  0, 1},
      '{1,   -9,    0, 0, -8,  0,  0, 1},
      '{2,  127, -128, 1,  7, -8,  0, 2},
      '{3, -128, -128, 0,  0, -8, -8, 2},
      '{3,    3,    5, 0, -2,  3,  5, 0},
      '{2,   -8,    7, 0, -8,  7,  0, 0}
   };
   vec_t stall_v [0:5] = '{
      '{3,   20,   -6, 1,  7,  7, -6, 2},
      '{3,   -3,    4, 0, -1, -3,  4, 0},
      '{3,  100,  100, 0,  0,  7,  7, 2},
      '{3,  -50,   10, 0,  7, -8,  7, 3},
      '{3,    1,    1, 0,  0,  1,  1, 0},
      '{3,    2,    2, 0,  0,  2,  2, 0}
   };

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int exp_osat();
`ifdef LLR_PSK_DEMAPPER_SAT_CNT_EN
      return (exp_sat > 65535) ? 65535 : exp_sat;
`else
      return 0;
`endif
   endfunction

   task automatic push_exp(input vec_t v);
      exp_t e;
      for (int k = 0; k < v.q; k++) begin
         e.llr  = 4'((k == 0) ? v.l0 : (k == 1) ? v.l1 : v.l2);
         e.sop  = (k == 0) && (v.sop != 0);
         e.last = (k == v.q - 1);
         sb.push_back(e);
      end
      exp_sat += v.nsat;
   endtask

   task automatic drive(input vec_t v);
      ival    = 1'b1;
      iqam    = 2'(v.q);
      idat_re = 8'(v.re);
      idat_im = 8'(v.im);
      isop    = (v.sop != 0);
      if (v.q != 0) push_exp(v);
   endtask

   // one symbol, accepted at the posedge following a negedge with ordy=1
   task automatic send(input vec_t v);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ordy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("send_ordy", int'(ordy), 1);
      drive(v);
      @(posedge clk); #1;
      ival = 1'b0;
      isop = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while ((sb.size() != 0 || oval) && guard < 200) begin
         @(negedge clk); #1;
         guard++;
      end
      check(name, sb.size(), 0);
   endtask

   // monitor: compare every presented LLR with the scoreboard head
   initial begin
      forever begin
         @(negedge clk);
         if (!ireset && oval) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL llr_out: got unexpected llr=%0d sop=%0b last=%0b, expected no output",
                        oLLR, osop, olast);
            end else begin
               if (oLLR !== sb[0].llr || osop !== sb[0].sop || olast !== sb[0].last) begin
                  n_fail++;
                  $display("FAIL llr_out: got llr=%0d sop=%0b last=%0b, expected llr=%0d sop=%0b last=%0b",
                           oLLR, osop, olast, sb[0].llr, sb[0].sop, sb[0].last);
               end
               if (irdy && iclkena) begin
                  void'(sb.pop_front());
                  n_pops++;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   lat, acc, base;
      ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; iqam = 2'd0;
      idat_re = '0; idat_im = '0; irdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ireset = 1'b0;

      // reset state
      check("rst_oval", int'(oval), 0);
      check("rst_ordy", int'(ordy), 1);
      check("rst_osop", int'(osop), 0);
      check("rst_olast", int'(olast), 0);
      check("rst_ollr", int'(oLLR), 0);
      check("rst_osat", int'(osat_cnt), 0);

      // QPSK with latency measurement
      v = '{2, 5, -3, 1, 5, -3, 0, 0};
      send(v);
      lat = 0;
      while (!oval && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("qpsk_latency", lat, 3);
      drain("qpsk_drain");
      check("qpsk_osat", int'(osat_cnt), exp_osat());

      // directed vectors, each drained before the next
      foreach (dir_v[i]) begin
         send(dir_v[i]);
         drain("dir_drain");
         check("dir_osat", int'(osat_cnt), exp_osat());
      end

      // back-to-back symbols
      foreach (dir_v[i]) send(dir_v[i]);
      drain("b2b_drain");
      check("b2b_osat", int'(osat_cnt), exp_osat());

      // iqam = 0 is discarded: no output, no saturation count
      v = '{0, 100, -100, 1, 0, 0, 0, 0};
      send(v);
      repeat (8) @(posedge clk);
      #1;
      check("qam0_no_oval", int'(oval), 0);
      check("qam0_osat", int'(osat_cnt), exp_osat());

      // stalled output: only pFIFO_DEPTH symbols get accepted
      @(posedge clk); #1;
      irdy = 1'b0;
      acc  = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ordy && acc < 6) begin
            drive(stall_v[acc]);
            acc++;
         end else begin
            ival = 1'b0;
         end
      end
      @(negedge clk);
      ival = 1'b0;
      isop = 1'b0;
      #1;
      check("stall_accepted", acc, 4);
      check("stall_ordy", int'(ordy), 0);
      check("stall_oval", int'(oval), 1);
      @(posedge clk); #1;
      base = n_pops;
      irdy = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("stall_burst_llrs", n_pops - base, 12);
      check("stall_burst_end", int'(oval), 0);
      drain("stall_drain");
      check("stall_osat", int'(osat_cnt), exp_osat());

      // reset with two symbols buffered
      @(posedge clk); #1;
      irdy = 1'b0;
      send(dir_v[5]);
      send(dir_v[8]);
      repeat (6) @(posedge clk);
      #1;
      ireset = 1'b1;
      sb.delete();
      exp_sat = 0;
      @(posedge clk); #1;
      check("midrst_oval", int'(oval), 0);
      check("midrst_ordy", int'(ordy), 1);
      check("midrst_osat", int'(osat_cnt), 0);
      ireset = 1'b0;
      irdy   = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("midrst_no_stale", int'(oval), 0);

      // recovery after reset
      send(dir_v[0]);
      drain("recover_drain");
      check("recover_osat", int'(osat_cnt), exp_osat());

      check("sb_empty_end", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/llr_psk_demapper_ser.md
LLR_PSK_DEMAPPER_SER -- requirements
Module: llr_psk_demapper_ser

Interface
REQ-001 SHALL have parameter pDAT_W, default 8, input I/Q sample width (signed).
REQ-002 SHALL have parameter pLLR_W, default 4, output LLR width (signed).
REQ-003 SHALL have parameter pFIFO_DEPTH, default 4, symbol FIFO depth in entries (>= 4).
REQ-004 SHALL have port iclk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port ireset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port iclkena  in  1  global clock enable; when low, all state holds.
REQ-007 SHALL have port ival  in  1  input symbol valid.
REQ-008 SHALL have port isop  in  1  start of packet, qualified by ival.
REQ-009 SHALL have port iqam  in  2  bits per symbol: 1 = BPSK, 2 = QPSK, 3 = 8PSK.
REQ-010 SHALL have ports idat_re, idat_im  in  pDAT_W each  signed I/Q sample.
REQ-011 SHALL have port ordy  out  1  upstream ready; a symbol is accepted when ival & ordy & iclkena.
REQ-012 SHALL have port irdy  in  1  downstream ready.
REQ-013 SHALL have port oval  out  1  output LLR valid; a transfer occurs when oval & irdy & iclkena.
REQ-014 SHALL have ports osop, olast  out  1 each: first LLR of a packet's first symbol; last LLR of each symbol.
REQ-015 SHALL have port oLLR  out  pLLR_W  signed serial LLR.
REQ-016 SHALL have port osat_cnt  out  16  saturation event count (see Configuration).

Function
REQ-017 SHALL compute, with full-precision (pDAT_W+1)-bit arithmetic: BPSK b0=re; QPSK b0=re, b1=im; 8PSK b0=|re|-|im|, b1=re, b2=im.
REQ-018 SHALL saturate each LLR to [-2^(pLLR_W-1), 2^(pLLR_W-1)-1]; in-range values pass unchanged.
REQ-019 SHALL discard accepted symbols with iqam = 0: no FIFO write, no output, no count.
REQ-020 SHALL use a 2-stage pipeline: stage 1 registers the inputs and |re|, |im|; stage 2 computes and saturates, then writes {LLRs, iqam, isop} to the FIFO.
REQ-021 SHALL deassert ordy when FIFO occupancy plus valid pipeline stages >= pFIFO_DEPTH, so that no symbol is ever dropped on overflow.
REQ-022 SHALL serialise each FIFO entry as iqam LLRs, in order b0, b1, b2, one per transfer, popping the entry on the transfer of its last LLR.
REQ-023 SHALL hold oval, oLLR, osop and olast stable while oval=1 and irdy=0.
REQ-024 SHALL give a latency of 3 cycles from the accept edge to first oval when the FIFO is empty and irdy=1, and sustain 1 LLR per cycle.
REQ-025 SHALL handle a same-cycle FIFO write and pop without loss; a write to a full FIFO SHALL be impossible by REQ-021.
REQ-026 SHALL wrap the FIFO pointers modulo pFIFO_DEPTH; pFIFO_DEPTH need not be a power of 2.

Reset
REQ-027 SHALL, on ireset=1 at a clock edge (regardless of iclkena), set oval=0, osop=0, olast=0, oLLR=0 and osat_cnt=0, clear the pipeline valids, empty the FIFO and zero the serialiser bit index.
REQ-028 SHALL drive ordy=1 on the first cycle after reset.
REQ-029 SHALL discard all symbols in flight when reset is asserted mid-stream, with no partial symbol emitted afterwards.

Configuration
REQ-030 SHALL, with macro LLR_PSK_DEMAPPER_SAT_CNT_EN defined, increment osat_cnt by the number of LLRs saturated per FIFO-written symbol (0..3), sticking at 0xFFFF.
REQ-031 SHALL, without LLR_PSK_DEMAPPER_SAT_CNT_EN, tie osat_cnt to 0 and synthesise no counter logic.

Verification (pDAT_W=8, pLLR_W=4, pFIFO_DEPTH=4, irdy=1 unless stated)
REQ-032 SHALL test: QPSK re=5, im=-3, isop=1 -> 3 cycles later oLLR=5 (osop=1, olast=0), then -3 (olast=1).
REQ-033 SHALL test: 8PSK re=20, im=-6 -> oLLR=7, 7, -6 with olast on the third; osat_cnt +2 when the macro is defined.
REQ-034 SHALL test: BPSK re=-100 -> single oLLR=-8 with olast=1; iqam=0 symbol -> no output, osat_cnt unchanged.
REQ-035 SHALL test: irdy=0 with 8PSK symbols streamed -> ordy falls after 4 accepted; on irdy=1, 12 LLRs emerge in order without loss and outputs stay stable while stalled.
REQ-036 SHALL test: ireset pulsed while 2 symbols are buffered -> next cycle oval=0 and ordy=1, osat_cnt=0, and no stale LLRs appear afterwards.
